// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: walks the OTP address bus, captures each read word,
// and queues {pc, instr} pairs for decode. A redirect flushes the queue and restarts fetch.
module ifu_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] otp_pa,
    input  logic [31:0] otp_pdataout,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   redirect_aligned;
    logic          push;
    logic          pop;

    // Handshake: a word transfers to decode on any edge where instr_valid && instr_ready
    // and no redirect is present; the head is held stable until that happens.
    assign instr_valid      = (count != '0);
    assign instr_data       = instr_valid ? data_mem[rd_ptr] : 32'h0;
    assign instr_pc         = instr_valid ? pc_mem[rd_ptr]   : 32'h0;
    assign otp_pa           = fetch_pc;
    assign redirect_aligned = redirect_pc & ~32'h3;

    assign pop  = instr_valid && instr_ready && !redirect_valid;
    // A pop frees a slot in the same edge, so a full queue still streams one word per cycle.
    assign push = !redirect_valid && fetch_en && ((count < DEPTH_C) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= otp_pdataout;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed vector table, randomized run against a queue model,
// and an asynchronous reset taken mid-stream.
module tb_ifu_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] otp_pa;
    logic [31:0] otp_pdataout;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int checks = 0;
    int errors = 0;

    ifu_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .otp_pa         (otp_pa),
        .otp_pdataout   (otp_pdataout),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    // OTP contents: mem[k] = k + 0x100
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr >> 2) + 32'h100;
    endfunction

    assign otp_pdataout = mem_word(otp_pa);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: queue of pending words plus the next fetch address
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;

    task automatic model_reset();
        mq.delete();
        m_pc = RESET_PC;
    endtask

    task automatic model_step(input logic en, input logic redir, input logic [31:0] rpc,
                              input logic rdy);
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (redir) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            do_pop  = (mq.size() > 0) && rdy;
            do_push = en && ((mq.size() < DEPTH) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.pc   = m_pc;
                e.data = mem_word(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic model_compare();
        logic [31:0] epc;
        logic [31:0] edata;
        epc   = 32'h0;
        edata = 32'h0;
        if (mq.size() > 0) begin
            epc   = mq[0].pc;
            edata = mq[0].data;
        end
        chk("rnd_otp_pa", otp_pa, m_pc);
        chk("rnd_valid", {31'h0, instr_valid}, {31'h0, mq.size() > 0});
        chk("rnd_instr_pc", instr_pc, epc);
        chk("rnd_instr_data", instr_data, edata);
    endtask

    // directed vectors: expected outputs at this negedge, then inputs for the next edge
    typedef struct {
        logic        en;
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pa;
        logic [31:0] exp_pc;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h4,         32'h0,         32'h100};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8,         32'h0,         32'h100};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'hC,         32'h0,         32'h100};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10,        32'h0,         32'h100};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h10,        32'h0,         32'h100};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10,        32'h0,         32'h100};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h14,        32'h4,         32'h101};
        vecs[8]  = '{1'b1, 1'b1, 32'h23,        1'b1, 1'b1, 32'h18,        32'h8,         32'h102};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h20,        32'h0,         32'h0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h24,        32'h20,        32'h108};
        vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1, 1'b0, 32'h24,        32'h0,         32'h0};
        vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0};
        vecs[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h4000_00FE};
        vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         32'hFFFF_FFFC, 32'h4000_00FF};
        vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         32'h0};
    end

    // driver tasks
    task automatic drive(input logic en, input logic redir, input logic [31:0] rpc,
                         input logic rdy);
        fetch_en       = en;
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_otp_pa", otp_pa, RESET_PC);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_instr_data", instr_data, 32'h0);

        // directed table
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("vec%0d_valid", i), {31'h0, instr_valid}, {31'h0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_otp_pa", i), otp_pa, vecs[i].exp_pa);
            chk($sformatf("vec%0d_instr_pc", i), instr_pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_instr_data", i), instr_data, vecs[i].exp_data);
            drive(vecs[i].en, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            @(negedge clk);
        end

        // table ends empty with fetch address 0
        mq.delete();
        m_pc = 32'h0;

        // randomized run against the model
        for (int c = 0; c < 600; c++) begin
            logic        en;
            logic        redir;
            logic [31:0] rpc;
            logic        rdy;
            model_compare();
            en    = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rdy   = ($urandom_range(0, 2) != 0);
            rpc   = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            drive(en, redir, rpc, rdy);
            model_step(en, redir, rpc, rdy);
            @(negedge clk);
        end

        // async reset with three words queued
        drive(1'b0, 1'b1, 32'h40, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre_arst_valid", {31'h0, instr_valid}, 32'h1);
        chk("pre_arst_instr_pc", instr_pc, 32'h40);
        chk("pre_arst_otp_pa", otp_pa, 32'h4C);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'h0, instr_valid}, 32'h0);
        chk("arst_instr_pc", instr_pc, 32'h0);
        chk("arst_instr_data", instr_data, 32'h0);
        chk("arst_otp_pa", otp_pa, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        model_step(1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        model_compare();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
